subleq_fetch: RTL and testbench

- Instruction fetch stage of the SUBLEQ core; holds the architectural PC and reads the three instruction words A, B, C at PC, PC+1, PC+2 from the unified memory port.
- Sits upstream of the PC-increment/branch stage: latched c feeds the branch target, pc feeds increment.
- Next-PC value from that stage loads back through pc_we between fetches.
- A negative PC (MSB set) is the halt condition.

---
 rtl/subleq_fetch.sv | 119 +++++++++++
 tb/tb_subleq_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_fetch.sv
// rtl/subleq_fetch.sv - SUBLEQ instruction fetch: holds PC, reads A/B/C words from the memory port
module subleq_fetch #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pc_we,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic              fetch_done,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] base;
    logic              ack_ok;
    logic              req_d;
    logic              busy_d;
    logic              done_d;

    // A same-cycle pc_we redirects the fetch to next_pc.
    assign base   = pc_we ? next_pc : pc;
    assign ack_ok = mem_req && mem_ack;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = base[ADDR_W-1] ? HALT : FETCH;
                end
            end
            FETCH: begin
                if (ack_ok && idx == 2'd2) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = HALT;
        endcase
    end

    always_comb begin
        req_d  = (state_next == FETCH);
        busy_d = (state_next == FETCH) || (state_next == DONE);
        done_d = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            pc         <= RESET_PC;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            mem_req    <= req_d;
            busy       <= busy_d;
            fetch_done <= done_d;
            if (state_next == HALT) begin
                halted <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pc_we) begin
                        pc <= next_pc;
                    end
                    if (start && !base[ADDR_W-1]) begin
                        idx      <= 2'd0;
                        mem_addr <= base;
                    end
                end
                FETCH: begin
                    if (ack_ok) begin
                        case (idx)
                            2'd0:    a <= mem_rdata;
                            2'd1:    b <= mem_rdata;
                            default: c <= mem_rdata;
                        endcase
                        // Next word request goes out back-to-back; address wraps naturally.
                        if (idx != 2'd2) begin
                            idx      <= idx + 2'd1;
                            mem_addr <= pc + ADDR_W'(idx) + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_fetch.sv
// tb/tb_subleq_fetch.sv - scoreboard bench for subleq_fetch with randomized memory waits
module tb_subleq_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pc_we = 1'b0;
    logic [63:0] next_pc = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] pc, a, b, c;
    logic        fetch_done, busy, halted;

    subleq_fetch #(.ADDR_W(64), .DATA_W(64), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_we(pc_we), .next_pc(next_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .a(a), .b(b), .c(c), .fetch_done(fetch_done), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc, a, b, c;
        int          done_edge;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_addr[$];
    logic [63:0] mem_ovr[logic [63:0]];
    int          wait_cfg[3];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [63:0] salt;
    logic [63:0] m_pc = 64'd0;
    bit          m_halted = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_val(input logic [63:0] addr);
        if (mem_ovr.exists(addr)) return mem_ovr[addr];
        return (addr * 64'h9E37_79B9_7F4A_7C15) ^ salt;
    endfunction

    // Memory responder: per-word wait counts from wait_cfg, spurious acks while idle.
    initial begin
        int  widx = 0;
        int  wleft = 0;
        bit  waiting = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                widx = 0;
                waiting = 0;
                mem_ack = !rst && ($urandom_range(0, 3) == 0);
                mem_rdata = {$urandom, $urandom};
            end else begin
                if (!waiting) begin
                    wleft = wait_cfg[widx];
                    waiting = 1;
                end
                if (exp_addr.size() == 0) begin
                    check("unexpected_mem_req", {63'd0, mem_req}, 64'd0);
                end
                if (wleft > 0) begin
                    wleft--;
                    mem_ack = 1'b0;
                    mem_rdata = {$urandom, $urandom};
                    if (exp_addr.size() != 0) check("addr_hold", mem_addr, exp_addr[0]);
                end else begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_val(mem_addr);
                    if (exp_addr.size() != 0) check("addr_ack", mem_addr, exp_addr.pop_front());
                    waiting = 0;
                    widx = (widx + 1) % 3;
                end
            end
        end
    end

    // Monitor: every fetch_done pulse must match the oldest outstanding fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && fetch_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_fetch_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_pc", pc, e.pc);
                    check("done_a", a, e.a);
                    check("done_b", b, e.b);
                    check("done_c", c, e.c);
                    check("done_latency", 64'(cyc + 1), 64'(e.done_edge));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_halted"}, {63'd0, halted}, {63'd0, m_halted});
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_req"}, {63'd0, mem_req}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_addr.delete();
        step();
        step();
        rst = 1'b0;
        m_pc = 64'd0;
        m_halted = 1'b0;
        check_idle("reset");
        check("reset_abc", a | b | c, 64'd0);
        check("reset_done", {63'd0, fetch_done}, 64'd0);
        check("reset_addr", mem_addr, 64'd0);
    endtask

    task automatic load_pc(input logic [63:0] npc);
        pc_we = 1'b1;
        next_pc = npc;
        if (!m_halted) m_pc = npc;
        step();
        pc_we = 1'b0;
    endtask

    // Issue one start and model its outcome: halt, ignore, or a three-word fetch.
    task automatic do_fetch(input bit we, input logic [63:0] npc, input int w0, input int w1, input int w2);
        exp_t        e;
        logic [63:0] base;
        bit          issued = 0;
        wait_cfg[0] = w0;
        wait_cfg[1] = w1;
        wait_cfg[2] = w2;
        start = 1'b1;
        pc_we = we;
        next_pc = npc;
        if (!m_halted) begin
            base = we ? npc : m_pc;
            m_pc = base;
            if (base[63]) begin
                m_halted = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) exp_addr.push_back(base + 64'(i));
                e.pc = base;
                e.a = mem_val(base);
                e.b = mem_val(base + 64'd1);
                e.c = mem_val(base + 64'd2);
                e.done_edge = cyc + 1 + 4 + w0 + w1 + w2;
                sb.push_back(e);
                issued = 1;
            end
        end
        step();
        start = 1'b0;
        pc_we = 1'b0;
        if (issued) begin
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                #1;
                if (sb.size() == 0) break;
            end
            if (sb.size() != 0) begin
                check("fetch_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                exp_addr.delete();
            end
        end
        step();
        step();
        check_idle("post_fetch");
    endtask

    initial begin
        salt = {$urandom, $urandom};
        do_reset();

        mem_ovr[64'd0] = 64'd5;
        mem_ovr[64'd1] = 64'd6;
        mem_ovr[64'd2] = 64'd9;
        do_fetch(0, 64'd0, 0, 0, 0);
        check("basic_a", a, 64'd5);
        check("basic_b", b, 64'd6);
        check("basic_c", c, 64'd9);

        do_fetch(1, 64'h30, 0, 0, 0);
        do_fetch(0, 64'h0, 0, 3, 0);

        for (int i = 0; i < 20; i++) begin
            do_fetch(1'($urandom_range(0, 1)), {1'b0, $urandom, 31'($urandom)},
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        do_fetch(1, 64'h7FFF_FFFF_FFFF_FFFE, 0, 1, 0);

        load_pc(64'hFFFF_FFFF_FFFF_FFFF);
        do_fetch(0, 64'h0, 0, 0, 0);
        check("halt_flag", {63'd0, halted}, 64'd1);
        do_fetch(1, 64'h40, 0, 0, 0);
        load_pc(64'h80);
        check_idle("halt_hold");
        do_reset();

        // Reset in the middle of word B; a pc_we pulse during the fetch must not land.
        wait_cfg[0] = 0;
        wait_cfg[1] = 6;
        wait_cfg[2] = 0;
        for (int i = 0; i < 3; i++) exp_addr.push_back(64'h200 + 64'(i));
        start = 1'b1;
        pc_we = 1'b1;
        next_pc = 64'h200;
        step();
        start = 1'b0;
        pc_we = 1'b0;
        step();
        start = 1'b1;
        pc_we = 1'b1;
        next_pc = 64'h999;
        step();
        start = 1'b0;
        pc_we = 1'b0;
        check("midfetch_pc", pc, 64'h200);
        check("midfetch_req", {63'd0, mem_req}, 64'd1);
        check("midfetch_addr", mem_addr, 64'h201);
        check("midfetch_a", a, mem_val(64'h200));
        rst = 1'b1;
        sb.delete();
        exp_addr.delete();
        step();
        rst = 1'b0;
        m_pc = 64'd0;
        m_halted = 1'b0;
        check_idle("after_rst");
        check("after_rst_abc", a | b | c, 64'd0);
        do_fetch(0, 64'h0, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
